mem_lsu: RTL

- Memory-stage load/store unit at the consuming end of the EX/ME pipeline register.
- Takes the M-stage address, store data, write enable, load/store type and writeback select, and turns them into a single-outstanding request on the data-memory bus.
- Formats byte/half/word store lanes and load data, and raises stall_M while an access is in flight.
- Sits between the EX/ME and ME/WB pipeline registers.

---
 rtl/mem_lsu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit issuing single-outstanding dmem requests.
// Ports: clk, rst_n (async, active-low); ALU_result_M, write_data_M, we_mem_M,
//   wb_ctrl_M, ls_type_M from EX/ME; dmem_req/we/addr/wstrb/wdata out and
//   dmem_ready/rdata in; load_data_M, stall_M, ls_err_M to the pipeline.
// Optional macro MISALIGN_TRAP_EN: trap misaligned / illegal-type accesses on
//   ls_err_M; when undefined, accesses are forced aligned and illegal types act as W.
module mem_lsu #(
    parameter int         ADDR_W      = 32,
    parameter logic [1:0] LOAD_WB_SEL = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ALU_result_M,
    input  logic [31:0]       write_data_M,
    input  logic              we_mem_M,
    input  logic [1:0]        wb_ctrl_M,
    input  logic [2:0]        ls_type_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_wstrb,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       load_data_M,
    output logic              stall_M,
    output logic              ls_err_M
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q;
    logic                req_q, we_q, is_load_q, uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q, ld_q;
    logic [1:0]          alo_q, size_q;

    logic       is_store, is_load, mem_op, illegal, err;
    logic [1:0] a, size, alo;
    logic       uns;
    logic [3:0] st_strb;
    logic [31:0] st_data, ld_fmt;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    // A store wins when both store and load are flagged.
    assign is_store = we_mem_M;
    assign is_load  = ~we_mem_M & (wb_ctrl_M == LOAD_WB_SEL);
    assign mem_op   = is_store | is_load;
    assign a        = ALU_result_M[1:0];

    assign illegal = is_store ? (ls_type_M[2] | (ls_type_M[1:0] == 2'b11))
                              : ((ls_type_M[1:0] == 2'b11) || (ls_type_M == 3'b110));

    // Illegal types collapse to a signed word access.
    assign size = illegal ? 2'b10 : ls_type_M[1:0];
    assign uns  = ~illegal & ls_type_M[2];

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((size == 2'b01) & a[0]) | ((size == 2'b10) & (a != 2'b00));
    assign err      = mem_op & (illegal | misalign);
`else
    assign err      = 1'b0;
`endif

    // Lane offset seen by formatting; truncated for half/word.
    always_comb begin
        alo = 2'b00;
        unique case (size)
            2'b00:   alo = a;
            2'b01:   alo = {a[1], 1'b0};
            default: alo = 2'b00;
        endcase
    end

    always_comb begin
        st_strb = 4'b1111;
        st_data = write_data_M;
        unique case (size)
            2'b00: begin
                st_strb = 4'b0001 << alo;
                st_data = {4{write_data_M[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << alo;
                st_data = {2{write_data_M[15:0]}};
            end
            default: ;
        endcase
    end

    assign bsel = dmem_rdata[8*alo_q +: 8];
    assign hsel = dmem_rdata[16*alo_q[1] +: 16];

    always_comb begin
        ld_fmt = dmem_rdata;
        unique case (size_q)
            2'b00:   ld_fmt = {{24{~uns_q & bsel[7]}}, bsel};
            2'b01:   ld_fmt = {{16{~uns_q & hsel[15]}}, hsel};
            default: ld_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            ld_q      <= 32'h0;
            alo_q     <= 2'b00;
            size_q    <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_op && !err) begin
                        state_q   <= WAIT;
                        req_q     <= 1'b1;
                        we_q      <= is_store;
                        is_load_q <= is_load;
                        uns_q     <= uns;
                        addr_q    <= {ALU_result_M[ADDR_W-1:2], 2'b00};
                        wstrb_q   <= is_store ? st_strb : 4'b0000;
                        wdata_q   <= is_store ? st_data : 32'h0;
                        alo_q     <= alo;
                        size_q    <= size;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state_q <= RESP;
                        req_q   <= 1'b0;
                        if (is_load_q)
                            ld_q <= ld_fmt;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wstrb  = wstrb_q;
    assign dmem_wdata  = wdata_q;
    assign load_data_M = ld_q;

    assign stall_M  = rst_n & (((state_q == IDLE) & mem_op & ~err) | (state_q == WAIT));
    assign ls_err_M = rst_n & (state_q == IDLE) & err;

endmodule
